lfsr_prpg_engine: RTL and testbench
===================================

Name: lfsr_prpg_engine

Overview:
- Parametrised command-driven pseudo-random pattern generator for the PRPG microprocessor family.
- Contains a WIDTH-bit programmable-tap LFSR, a DEPTH-entry pattern store and an address register.
- Computes the Hamming distance (HD) of every step and keeps running HD statistics.
- A multi-cycle sequential divider produces the average HD.
- Sits behind the instruction decoder, which issues one command per valid/ready handshake.

Parameters:
- WIDTH, 8, LFSR and pattern width (≥4).
- DEPTH, 256, pattern-store entries (power of 2); AW = $clog2(DEPTH).
- SUM_W, 16, width of HD-sum accumulator, run counter and divider.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_op  in  4  opcode (package enum).
- cmd_arg  in  WIDTH  operand.
- q  out  WIDTH  current LFSR state.
- q_valid  out  1  one-cycle pulse per LFSR step.
- hd  out  $clog2(WIDTH+1)  HD of the last step.
- rsp_valid  out  1  one-cycle pulse with rsp_data.
- rsp_data  out  SUM_W  LOAD/AVG result, zero-extended.
- rsp_err  out  1  qualifies rsp_valid (AVG with zero runs).
- halted  out  1  HALT executed.

Behaviour:
- Reset:
  - q, tap, addr, sum, runs, hd, rsp_data = 0.
  - q_valid, rsp_valid, rsp_err, halted = 0.
  - State IDLE; cmd_ready = 1. Memory contents are not reset.
  - rst mid-RUN or mid-DIV aborts the operation and suppresses any pending response.
- Handshake: a command is accepted on an edge where cmd_valid && cmd_ready. cmd_ready = (state == IDLE).
- Step function, with m = q[WIDTH-1]:
  - q'[0] = m.
  - q'[i] = q[i-1] ^ (tap[i] & m) for i = 1..WIDTH-1.
  - tap[0] is ignored.
  - Per step: hd = popcount(q ^ q'); sum += hd and runs += 1, both saturating at 2^SUM_W-1.
- Opcodes (IDLE, single-cycle; results visible the edge after acceptance):
  - NOP=0: no effect.
  - CFG_TAP=1: tap ← arg.
  - SEED=2: q ← arg; stats untouched.
  - STORE=4: mem[addr] ← q.
  - LOAD=5: q ← mem[addr], with rsp_valid and rsp_data = mem[addr] one cycle later. Not counted as a step.
  - SET_ADDR=6: addr ← arg[AW-1:0].
  - ADD_ADDR=7: addr ← (addr + arg) mod DEPTH (wraps).
  - CLR_STATS=8: sum, runs, hd ← 0.
  - Undefined opcodes behave as NOP.
- RUN=3 (multi-cycle):
  - arg = N steps. N = 0 behaves as NOP.
  - Otherwise enter RUN and perform exactly one step per cycle for N cycles, starting the edge after acceptance.
  - q_valid is high on each step edge; return to IDLE after the Nth step.
- AVG=9 (multi-cycle):
  - runs = 0: next cycle rsp_valid = 1, rsp_err = 1, rsp_data = 0; no DIV state is entered.
  - Otherwise enter DIV: restoring divider, one quotient bit per cycle, SUM_W cycles.
  - rsp_valid with rsp_data = sum / runs (floor) on the cycle after the last iteration; then IDLE.
  - Total latency: SUM_W+1 cycles from acceptance.
- HALT=15: enter HALT; halted = 1 and cmd_ready = 0 until rst.
- State machine: IDLE → RUN → IDLE; IDLE → DIV → IDLE; IDLE → HALT. Commands are never queued.
- Output timing: q_valid and rsp_valid are registered pulses and never coincide.
- Memory: single-port, write on STORE, synchronous read on LOAD.

Decomposition:
- Package lfsr_prpg_pkg holds:
  - The op_e enum (4-bit codes above).
  - The state_e enum {IDLE, RUN, DIV, HALT}.
  - A popcount function.
- Sub-module lfsr_seq_div (SUM_W): start/done restoring divider, dividend and divisor in, quotient out.
- Step logic and memory stay in the top level.

Test Plan:
- WIDTH=8; rst, then CFG_TAP 0x1C, SEED 0x80, RUN 1 → q=0x1D, hd=5, q_valid for exactly 1 cycle.
- SEED 0x01, CLR_STATS, RUN 4 → q=0x02,0x04,0x08,0x10 on consecutive cycles; hd=2 each; cmd_ready low 4 cycles; then AVG → rsp_data=2 after 17 cycles, rsp_err=0.
- CLR_STATS, AVG → rsp_valid next cycle with rsp_err=1, rsp_data=0.
- SET_ADDR 0xFE, STORE, ADD_ADDR 3 (addr=0x01), SEED 0x00, SET_ADDR 0xFE, LOAD → q and rsp_data equal the stored pattern.
- RUN 10, assert rst on the 3rd step → q=0, runs=0, cmd_ready=1 next cycle, no rsp_valid.
- HALT, then drive cmd_valid with RUN 5 → halted=1, cmd_ready=0, q unchanged until rst.

Source files
------------

// File: rtl/lfsr_prpg_pkg.sv
// Shared opcode/state encodings and helpers for the PRPG engine.
// Imported by the engine top level and its sequential divider.
package lfsr_prpg_pkg;

   typedef enum logic [3:0] {
      OP_NOP       = 4'd0,
      OP_CFG_TAP   = 4'd1,
      OP_SEED      = 4'd2,
      OP_RUN       = 4'd3,
      OP_STORE     = 4'd4,
      OP_LOAD      = 4'd5,
      OP_SET_ADDR  = 4'd6,
      OP_ADD_ADDR  = 4'd7,
      OP_CLR_STATS = 4'd8,
      OP_AVG       = 4'd9,
      OP_HALT      = 4'd15
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DIV,
      ST_HALT
   } state_e;

   function automatic logic [6:0] popcount(input logic [63:0] v);
      logic [6:0] c;
      c = '0;
      for (int i = 0; i < 64; i++)
         c = c + 7'(v[i]);
      return c;
   endfunction

endpackage

// File: rtl/lfsr_prpg_engine_div.sv
// Start/done restoring divider: one quotient bit per cycle, SUM_W cycles.
// done_o pulses for one cycle after the last iteration.
module lfsr_seq_div
   import lfsr_prpg_pkg::*;
#(
   parameter int SUM_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [SUM_W-1:0] dividend_i,
   input  logic [SUM_W-1:0] divisor_i,
   output logic             done_o,
   output logic [SUM_W-1:0] quotient_o
);

   localparam int CW = $clog2(SUM_W + 1);

   logic             busy_q;
   logic             done_q;
   logic [CW-1:0]    cnt_q;
   logic [SUM_W-1:0] quo_q;
   logic [SUM_W-1:0] rem_q;
   logic [SUM_W-1:0] div_q;
   logic [SUM_W:0]   shift_d;
   logic [SUM_W-1:0] rem_d;
   logic             ge_d;

   always_comb begin
      shift_d = {rem_q, quo_q[SUM_W-1]};
      ge_d    = shift_d >= {1'b0, div_q};
      rem_d   = ge_d ? SUM_W'(shift_d - {1'b0, div_q})
                     : shift_d[SUM_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         cnt_q  <= '0;
         quo_q  <= '0;
         rem_q  <= '0;
         div_q  <= '0;
      end else begin
         done_q <= 1'b0;
         if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= CW'(SUM_W);
            quo_q  <= dividend_i;
            rem_q  <= '0;
            div_q  <= divisor_i;
         end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= {quo_q[SUM_W-2:0], ge_d};
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign done_o     = done_q;
   assign quotient_o = quo_q;

endmodule

// File: rtl/lfsr_prpg_engine.sv
// Command-driven programmable-tap LFSR with pattern store and
// running Hamming-distance statistics.
module lfsr_prpg_engine
   import lfsr_prpg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 256,
   parameter int SUM_W = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [3:0]                   cmd_op,
   input  logic [WIDTH-1:0]             cmd_arg,
   output logic [WIDTH-1:0]             q,
   output logic                         q_valid,
   output logic [$clog2(WIDTH+1)-1:0]   hd,
   output logic                         rsp_valid,
   output logic [SUM_W-1:0]             rsp_data,
   output logic                         rsp_err,
   output logic                         halted
);

   localparam int AW  = $clog2(DEPTH);
   localparam int HW  = $clog2(WIDTH + 1);
   localparam int SW1 = SUM_W + 1;

   state_e           state_q;
   logic [WIDTH-1:0] lfsr_q;
   logic [WIDTH-1:1] tap_q;
   logic [AW-1:0]    addr_q;
   logic [SUM_W-1:0] sum_q;
   logic [SUM_W-1:0] runs_q;
   logic [HW-1:0]    hd_q;
   logic [WIDTH-1:0] cnt_q;
   logic             qv_q;
   logic             rspv_q;
   logic             rsperr_q;
   logic [SUM_W-1:0] rspdata_q;
   logic             halted_q;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [WIDTH-1:0] step_d;
   logic [HW-1:0]    hd_d;
   logic [SW1-1:0]   sum_ext;
   logic [SUM_W-1:0] sum_d;
   logic [SUM_W-1:0] runs_d;
   logic             msb;
   logic             accept;
   logic             div_start;
   logic             div_done;
   logic [SUM_W-1:0] div_quo;
   op_e              op;

   assign op        = op_e'(cmd_op);
   assign accept    = cmd_valid && (state_q == ST_IDLE);
   assign div_start = accept && !rst && (op == OP_AVG) && (runs_q != '0);

   // Galois step: shift up, feed msb into bit 0 and every tapped bit.
   always_comb begin
      msb     = lfsr_q[WIDTH-1];
      step_d  = {lfsr_q[WIDTH-2:0], msb} ^ ({tap_q, 1'b0} & {WIDTH{msb}});
      hd_d    = HW'(popcount(64'(lfsr_q ^ step_d)));
      sum_ext = {1'b0, sum_q} + SW1'(hd_d);
      sum_d   = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
      runs_d  = (&runs_q) ? runs_q : runs_q + SUM_W'(1);
   end

   always_ff @(posedge clk) begin
      if (accept && !rst && (op == OP_STORE))
         mem_q[addr_q] <= lfsr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         lfsr_q    <= '0;
         tap_q     <= '0;
         addr_q    <= '0;
         sum_q     <= '0;
         runs_q    <= '0;
         hd_q      <= '0;
         cnt_q     <= '0;
         qv_q      <= 1'b0;
         rspv_q    <= 1'b0;
         rsperr_q  <= 1'b0;
         rspdata_q <= '0;
         halted_q  <= 1'b0;
      end else begin
         qv_q     <= 1'b0;
         rspv_q   <= 1'b0;
         rsperr_q <= 1'b0;
         case (state_q)
            ST_IDLE: if (cmd_valid) begin
               case (op)
                  OP_CFG_TAP:  tap_q  <= cmd_arg[WIDTH-1:1];
                  OP_SEED:     lfsr_q <= cmd_arg;
                  OP_RUN: if (cmd_arg != '0) begin
                     cnt_q   <= cmd_arg;
                     state_q <= ST_RUN;
                  end
                  OP_LOAD: begin
                     lfsr_q    <= mem_q[addr_q];
                     rspv_q    <= 1'b1;
                     rspdata_q <= SUM_W'(mem_q[addr_q]);
                  end
                  OP_SET_ADDR: addr_q <= AW'(cmd_arg);
                  OP_ADD_ADDR: addr_q <= addr_q + AW'(cmd_arg);
                  OP_CLR_STATS: begin
                     sum_q  <= '0;
                     runs_q <= '0;
                     hd_q   <= '0;
                  end
                  OP_AVG: if (runs_q == '0) begin
                     rspv_q    <= 1'b1;
                     rsperr_q  <= 1'b1;
                     rspdata_q <= '0;
                  end else begin
                     state_q <= ST_DIV;
                  end
                  OP_HALT: begin
                     state_q  <= ST_HALT;
                     halted_q <= 1'b1;
                  end
                  default: ;
               endcase
            end
            ST_RUN: begin
               lfsr_q <= step_d;
               hd_q   <= hd_d;
               sum_q  <= sum_d;
               runs_q <= runs_d;
               qv_q   <= 1'b1;
               cnt_q  <= cnt_q - WIDTH'(1);
               if (cnt_q == WIDTH'(1))
                  state_q <= ST_IDLE;
            end
            ST_DIV: if (div_done) begin
               rspv_q    <= 1'b1;
               rspdata_q <= div_quo;
               state_q   <= ST_IDLE;
            end
            default: ;
         endcase
      end
   end

   lfsr_seq_div #(.SUM_W(SUM_W)) u_div (
      .clk        (clk),
      .rst        (rst),
      .start_i    (div_start),
      .dividend_i (sum_q),
      .divisor_i  (runs_q),
      .done_o     (div_done),
      .quotient_o (div_quo)
   );

   assign cmd_ready = (state_q == ST_IDLE);
   assign q         = lfsr_q;
   assign q_valid   = qv_q;
   assign hd        = hd_q;
   assign rsp_valid = rspv_q;
   assign rsp_data  = rspdata_q;
   assign rsp_err   = rsperr_q;
   assign halted    = halted_q;

endmodule

// File: tb/tb_lfsr_prpg_engine.sv
// Self-checking bench for lfsr_prpg_engine: directed plan plus
// random command stream against a behavioural model.
module tb_lfsr_prpg_engine;

   localparam int WIDTH = 8;
   localparam int DEPTH = 256;
   localparam int SUM_W = 16;
   localparam int HW    = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [3:0]       cmd_op;
   logic [WIDTH-1:0] cmd_arg;
   logic [WIDTH-1:0] q;
   logic             q_valid;
   logic [HW-1:0]    hd;
   logic             rsp_valid;
   logic [SUM_W-1:0] rsp_data;
   logic             rsp_err;
   logic             halted;

   always #5 clk = ~clk;

   lfsr_prpg_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SUM_W(SUM_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_arg   (cmd_arg),
      .q         (q),
      .q_valid   (q_valid),
      .hd        (hd),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .halted    (halted)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] mq, mtap, maddr;
   logic [3:0] mhd;
   int         msum, mruns;
   logic [7:0] mmem [DEPTH];
   bit         mwr  [DEPTH];

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   // Multiply by x modulo the tap polynomial (bit 0 always set).
   function automatic logic [7:0] nxt(input logic [7:0] s, input logic [7:0] t);
      int v;
      v = int'(s) * 2;
      if (v >= 256)
         v = (v - 256) ^ ((int'(t) & 'hFE) | 1);
      return 8'(v);
   endfunction

   function automatic int sat(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   task automatic model_reset();
      mq = '0; mtap = '0; maddr = '0; mhd = '0; msum = 0; mruns = 0;
   endtask

   task automatic issue(input logic [3:0] op, input logic [7:0] arg);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0;
   endtask

   task automatic pulse_idle();
      @(posedge clk); #1;
      check_eq("qv_drop", q_valid, 0);
      check_eq("rsp_drop", rsp_valid, 0);
      check_eq("rdy_idle", cmd_ready, 1);
   endtask

   task automatic exec(input logic [3:0] op, input logic [7:0] arg);
      logic        exp_rv, exp_re;
      logic [15:0] exp_rd;
      logic [7:0]  p;
      int          c;
      exp_rv = 0; exp_re = 0; exp_rd = '0;
      issue(op, arg);
      case (op)
         4'd1: mtap = arg;
         4'd2: mq = arg;
         4'd4: begin mmem[maddr] = mq; mwr[maddr] = 1; end
         4'd5: begin mq = mmem[maddr]; exp_rv = 1; exp_rd = {8'h0, mq}; end
         4'd6: maddr = arg;
         4'd7: maddr = maddr + arg;
         4'd8: begin msum = 0; mruns = 0; mhd = '0; end
         4'd9: if (mruns == 0) begin exp_rv = 1; exp_re = 1; end
         default: ;
      endcase
      if (op == 4'd3 && arg != 0) begin
         check_eq("run_busy", cmd_ready, 0);
         for (int k = 1; k <= int'(arg); k++) begin
            @(posedge clk); #1;
            p = mq;
            mq = nxt(mq, mtap);
            mhd = 4'($countones(p ^ mq));
            msum = sat(msum + int'(mhd));
            mruns = sat(mruns + 1);
            check_eq("step_q", q, mq);
            check_eq("step_hd", hd, mhd);
            check_eq("step_qv", q_valid, 1);
            check_eq("step_rsp", rsp_valid, 0);
            check_eq("step_rdy", cmd_ready, k == int'(arg));
         end
      end else if (op == 4'd9 && mruns != 0) begin
         check_eq("div_busy", cmd_ready, 0);
         c = 0;
         while (c < 40 && !rsp_valid) begin
            @(posedge clk); #1;
            c++;
         end
         check_eq("avg_lat", c, SUM_W + 1);
         check_eq("avg_data", rsp_data, msum / mruns);
         check_eq("avg_err", rsp_err, 0);
      end else if (op == 4'd15) begin
         check_eq("halt_flag", halted, 1);
         check_eq("halt_rdy", cmd_ready, 0);
      end else begin
         check_eq("op_q", q, mq);
         check_eq("op_hd", hd, mhd);
         check_eq("op_qv", q_valid, 0);
         check_eq("op_rv", rsp_valid, exp_rv);
         check_eq("op_re", rsp_err, exp_re);
         if (exp_rv)
            check_eq("op_rd", rsp_data, exp_rd);
         check_eq("op_rdy", cmd_ready, 1);
      end
      if (op != 4'd15)
         pulse_idle();
   endtask

   initial begin
      logic [3:0] rop;
      logic [7:0] rarg;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0;
      model_reset();
      for (int i = 0; i < DEPTH; i++) mwr[i] = 0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_q", q, 0);
      check_eq("rst_qv", q_valid, 0);
      check_eq("rst_hd", hd, 0);
      check_eq("rst_rv", rsp_valid, 0);
      check_eq("rst_rd", rsp_data, 0);
      check_eq("rst_re", rsp_err, 0);
      check_eq("rst_halt", halted, 0);
      check_eq("rst_rdy", cmd_ready, 1);
      @(negedge clk); rst = 1'b0;

      exec(4'd1, 8'h1C);
      exec(4'd2, 8'h80);
      exec(4'd3, 8'd1);
      check_eq("t1_q", q, 8'h1D);
      check_eq("t1_hd", hd, 5);

      exec(4'd2, 8'h01);
      exec(4'd8, 8'h00);
      exec(4'd3, 8'd4);
      check_eq("t2_q", q, 8'h10);
      exec(4'd9, 8'h00);
      check_eq("t2_avg", rsp_data, 2);

      exec(4'd8, 8'h00);
      exec(4'd9, 8'h00);

      exec(4'd6, 8'hFE);
      exec(4'd4, 8'h00);
      exec(4'd7, 8'd3);
      exec(4'd2, 8'h00);
      exec(4'd6, 8'hFE);
      exec(4'd5, 8'h00);
      check_eq("t4_load", q, 8'h10);

      for (int n = 0; n < 150; n++) begin
         rop  = 4'($urandom_range(0, 14));
         rarg = 8'($urandom);
         if (rop == 4'd3) rarg = 8'($urandom_range(0, 6));
         if (rop == 4'd5 && !mwr[maddr]) rop = 4'd4;
         exec(rop, rarg);
      end

      issue(4'd3, 8'd10);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk); rst = 1'b0;
      model_reset();
      check_eq("mid_q", q, 0);
      check_eq("mid_rdy", cmd_ready, 1);
      check_eq("mid_hd", hd, 0);
      check_eq("mid_rv", rsp_valid, 0);
      @(posedge clk); #1;
      check_eq("mid_qv", q_valid, 0);
      check_eq("mid_rv2", rsp_valid, 0);
      exec(4'd9, 8'h00);

      exec(4'd1, 8'hB8);
      exec(4'd2, 8'h5A);
      exec(4'd15, 8'h00);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 4'd3; cmd_arg = 8'd5;
      repeat (6) begin
         @(posedge clk); #1;
         check_eq("hlt_flag", halted, 1);
         check_eq("hlt_rdy", cmd_ready, 0);
         check_eq("hlt_q", q, mq);
         check_eq("hlt_qv", q_valid, 0);
      end
      @(negedge clk);
      cmd_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      check_eq("unhalt", halted, 0);
      check_eq("unhalt_rdy", cmd_ready, 1);
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
